// File: rtl/fsa_render.sv
// fsa_render: reads per-column {valid, top, bottom} records back from the
// column-state BRAM and renders them as an AXI4-Stream video frame.
// Reads are credit-limited so that every in-flight read always has a slot
// in the output buffer, which makes overflow impossible.
module fsa_render #(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_IMG_HW      = 12,
    parameter int C_IMG_WW      = 12,
    parameter int BR_DW         = 32,
    parameter int BR_AW         = 12,
    parameter int C_RD_LATENCY  = 2,
    parameter int C_FIFO_DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [C_IMG_HW-1:0]      height,
    input  logic [C_IMG_WW-1:0]      width,
    input  logic [C_PIXEL_WIDTH-1:0] fg_data,
    input  logic [C_PIXEL_WIDTH-1:0] bg_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     rd_en,
    output logic [BR_AW-1:0]         rd_addr,
    input  logic [BR_DW-1:0]         rd_data,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);
    localparam int FAW = $clog2(C_FIFO_DEPTH);
    localparam int CW  = FAW + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // side-band travelling alongside a BRAM read
    typedef struct packed {
        logic [C_IMG_HW-1:0] y;
        logic                first;
        logic                eol;
    } sb_t;

    // one output beat as held in the buffer
    typedef struct packed {
        logic [C_PIXEL_WIDTH-1:0] pix;
        logic                     first;
        logic                     eol;
    } beat_t;

    state_t                   state, state_nx;
    logic [C_IMG_HW-1:0]      h_r, y;
    logic [C_IMG_WW-1:0]      w_r, x;
    logic [C_PIXEL_WIDTH-1:0] fg_r, bg_r;
    logic [FAW:0]             fifo_cnt, inflight;
    logic [FAW-1:0]           wr_ptr, rd_ptr;
    beat_t                    mem [C_FIFO_DEPTH];
    logic [C_RD_LATENCY:1]    vld_pipe;
    sb_t  [C_RD_LATENCY:1]    sb_pipe;

    logic       x_end, y_end, issue, accept, push, pop, hit;
    logic [CW-1:0] credit_sum;
    sb_t        sb_in, sb_out;
    beat_t      head;
    logic       rec_v;
    logic [C_IMG_HW-1:0] rec_top, rec_bot;
    logic       unused_rd;

    assign x_end  = (x == w_r - C_IMG_WW'(1));
    assign y_end  = (y == h_r - C_IMG_HW'(1));
    assign accept = (state == IDLE) && start && (height != '0) && (width != '0);

    // a read may only go out if the buffer can absorb it plus everything already owed
    assign credit_sum = CW'(fifo_cnt) + CW'(inflight) + CW'(1);
    assign issue      = (state == RUN) && (credit_sum <= CW'(C_FIFO_DEPTH));

    assign sb_in.y     = y;
    assign sb_in.first = (x == '0) && (y == '0);
    assign sb_in.eol   = x_end;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // FSM next state: drain waits until nothing is owed and the buffer is empty
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (issue && x_end && y_end) state_nx = DRAIN;
            DRAIN:   if ((inflight == '0) && (fifo_cnt == '0)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // frame parameters latched at start; raster position advances per issued read
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_r  <= '0;
            w_r  <= '0;
            fg_r <= '0;
            bg_r <= '0;
            x    <= '0;
            y    <= '0;
        end else if (accept) begin
            h_r  <= height;
            w_r  <= width;
            fg_r <= fg_data;
            bg_r <= bg_data;
            x    <= '0;
            y    <= '0;
        end else if (issue) begin
            if (x_end) begin
                x <= '0;
                y <= y + C_IMG_HW'(1);
            end else begin
                x <= x + C_IMG_WW'(1);
            end
        end
    end

    // side-band shift register matched to the BRAM read latency
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            sb_pipe  <= '0;
        end else begin
            vld_pipe[1] <= issue;
            sb_pipe[1]  <= sb_in;
            for (int k = 2; k <= C_RD_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                sb_pipe[k]  <= sb_pipe[k-1];
            end
        end
    end

    assign push   = vld_pipe[C_RD_LATENCY];
    assign sb_out = sb_pipe[C_RD_LATENCY];

    assign rec_bot   = rd_data[C_IMG_HW-1:0];
    assign rec_top   = rd_data[2*C_IMG_HW-1:C_IMG_HW];
    assign rec_v     = rd_data[2*C_IMG_HW];
    assign unused_rd = ^rd_data[BR_DW-1:2*C_IMG_HW+1];
    assign hit       = rec_v && (rec_top <= sb_out.y) && (sb_out.y <= rec_bot);

    // reads owed: up on issue, down on return
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) inflight <= '0;
        else if (issue && !push) inflight <= inflight + 1'b1;
        else if (!issue && push) inflight <= inflight - 1'b1;
    end

    // buffer storage, written when a read returns
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pix: hit ? fg_r : bg_r, first: sb_out.first, eol: sb_out.eol};
    end

    // buffer pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = (fifo_cnt != '0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata  = m_axis_tvalid ? head.pix : '0;
    assign m_axis_tuser  = m_axis_tvalid && head.first;
    assign m_axis_tlast  = m_axis_tvalid && head.eol;

    assign busy    = (state != IDLE);
    assign rd_en   = issue;
    assign rd_addr = BR_AW'(x);
endmodule

// File: tb/tb_fsa_render.sv
// Bench for fsa_render: three builds (read latency 1, 2, 3) share stimulus.
// A model fills expected beats per frame; a monitor collects handshaked beats.
module tb_fsa_render;
    localparam int PW = 8, HW = 12, WW = 12, DW = 32, DEPTH = 8, ND = 3;

    typedef struct {
        logic [PW-1:0] d;
        logic          u;
        logic          l;
        int            cyc;
    } beat_t;

    logic clk = 1'b0;
    logic resetn;
    logic [HW-1:0] height;
    logic [WW-1:0] width;
    logic [PW-1:0] fg, bg;
    logic [ND-1:0] start_v;
    logic tready;
    logic rand_mode, rdy_fix;

    wire [ND-1:0]         busy, rd_en, tv, tu, tl;
    wire [ND-1:0][WW-1:0] rd_addr;
    wire [ND-1:0][DW-1:0] rd_data;
    wire [ND-1:0][PW-1:0] td;

    logic [DW-1:0] bram [16];

    int checks = 0, errors = 0, cyc = 0;
    beat_t exp_q [ND][$];
    beat_t obs_q [ND][$];
    int stall_err [ND];
    int outst [ND];
    int max_out [ND];
    int rd_cnt [ND];
    logic prev_stall [ND];
    logic [PW+1:0] prev_head [ND];

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < ND; g++) begin : g_dut
        localparam int L = g + 1;
        logic [WW-1:0] ap [1:L];
        always @(posedge clk) begin
            ap[1] <= rd_addr[g];
            for (int k = 2; k <= L; k++) ap[k] <= ap[k-1];
        end
        assign rd_data[g] = bram[ap[L][3:0]];
        fsa_render #(.C_RD_LATENCY(L), .C_FIFO_DEPTH(DEPTH)) u_dut (
            .clk(clk), .resetn(resetn), .height(height), .width(width),
            .fg_data(fg), .bg_data(bg), .start(start_v[g]), .busy(busy[g]),
            .rd_en(rd_en[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]),
            .m_axis_tvalid(tv[g]), .m_axis_tdata(td[g]), .m_axis_tuser(tu[g]),
            .m_axis_tlast(tl[g]), .m_axis_tready(tready)
        );
    end

    always @(posedge clk) begin
        #1 tready = rand_mode ? ($urandom_range(0, 99) < 30) : rdy_fix;
    end

    // monitor: collect beats, watch stall stability and outstanding credits
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < ND; i++) begin
            if (!resetn) begin
                prev_stall[i] = 1'b0;
                outst[i] = 0;
            end else begin
                if (prev_stall[i] && (!tv[i] || {td[i], tu[i], tl[i]} !== prev_head[i])) stall_err[i]++;
                if (tv[i] && tready) obs_q[i].push_back('{td[i], tu[i], tl[i], cyc});
                if (rd_en[i]) begin rd_cnt[i]++; outst[i]++; end
                if (tv[i] && tready) outst[i]--;
                if (outst[i] > max_out[i]) max_out[i] = outst[i];
                prev_stall[i] = tv[i] && !tready;
                prev_head[i] = {td[i], tu[i], tl[i]};
            end
        end
    end

    function automatic logic [31:0] rec(input bit v, input int t, input int b);
        return {7'b0, v, 12'(t), 12'(b)};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [ND-1:0] mask, input int w, input int h);
        logic [31:0] r;
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++) begin
                r = bram[xx];
                for (int i = 0; i < ND; i++)
                    if (mask[i])
                        exp_q[i].push_back('{(r[24] && int'(r[23:12]) <= yy && yy <= int'(r[11:0])) ? fg : bg,
                                            (xx == 0 && yy == 0), (xx == w - 1), 0});
            end
    endtask

    task automatic go(input logic [ND-1:0] mask, input int w, input int h);
        width = WW'(w);
        height = HW'(h);
        start_v = mask;
        tick();
        start_v = '0;
    endtask

    task automatic wait_done(input logic [ND-1:0] mask, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 4000 && !ok; n++) begin
            tick();
            ok = 1'b1;
            for (int i = 0; i < ND; i++)
                if (mask[i] && (obs_q[i].size() < exp_q[i].size() || busy[i])) ok = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic load_4x3();
        bram[0] = rec(1, 0, 2);
        bram[1] = rec(0, 0, 2);
        bram[2] = rec(1, 1, 1);
        bram[3] = rec(1, 2, 0);
        fg = 8'hFF;
        bg = 8'h00;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start_v = '0;
        rand_mode = 1'b0;
        rdy_fix = 1'b1;
        width = '0;
        height = '0;
        fg = '0;
        bg = '0;
        tick();
        tick();
        for (int i = 0; i < ND; i++) begin
            checks++;
            if ({busy[i], rd_en[i], rd_addr[i], tv[i], td[i], tu[i], tl[i]} !== '0) begin
                errors++;
                $display("FAIL reset dut%0d: outputs=%h, want 0", i, {busy[i], rd_en[i], rd_addr[i], tv[i], td[i], tu[i], tl[i]});
            end
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_frame_4x3();
        bit ok;
        beat_t e, o;
        load_4x3();
        rand_mode = 1'b0;
        rdy_fix = 1'b1;
        push_frame('1, 4, 3);
        go('1, 4, 3);
        wait_done('1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL 4x3 timeout: done=%0b, want 1", ok); end
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (obs_q[i].size() < 12 || obs_q[i][11].cyc - obs_q[i][0].cyc != 11) begin
                errors++;
                $display("FAIL 4x3 dut%0d rate: beats=%0d span=%0d, want 12 beats span 11", i, obs_q[i].size(),
                         obs_q[i].size() >= 12 ? obs_q[i][11].cyc - obs_q[i][0].cyc : -1);
            end
            while (exp_q[i].size() != 0) begin
                e = exp_q[i].pop_front();
                checks++;
                if (obs_q[i].size() == 0) begin
                    errors++; $display("FAIL 4x3 dut%0d beat: got none, want %h/%b/%b", i, e.d, e.u, e.l);
                end else begin
                    o = obs_q[i].pop_front();
                    if ({o.d, o.u, o.l} !== {e.d, e.u, e.l}) begin
                        errors++; $display("FAIL 4x3 dut%0d beat: got %h/%b/%b, want %h/%b/%b", i, o.d, o.u, o.l, e.d, e.u, e.l);
                    end
                end
            end
            checks++;
            if (obs_q[i].size() != 0) begin errors++; $display("FAIL 4x3 dut%0d extra: got %0d beats, want 0", i, obs_q[i].size()); obs_q[i].delete(); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        beat_t e, o;
        load_4x3();
        for (int i = 0; i < ND; i++) begin stall_err[i] = 0; max_out[i] = 0; end
        rand_mode = 1'b1;
        push_frame('1, 4, 3);
        go('1, 4, 3);
        wait_done('1, ok);
        rand_mode = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL backpressure timeout: done=%0b, want 1", ok); end
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (stall_err[i] != 0) begin errors++; $display("FAIL backpressure dut%0d stall stability: got %0d violations, want 0", i, stall_err[i]); end
            checks++;
            if (max_out[i] > DEPTH) begin errors++; $display("FAIL backpressure dut%0d credits: got %0d, want <= %0d", i, max_out[i], DEPTH); end
            while (exp_q[i].size() != 0) begin
                e = exp_q[i].pop_front();
                checks++;
                if (obs_q[i].size() == 0) begin
                    errors++; $display("FAIL backpressure dut%0d beat: got none, want %h/%b/%b", i, e.d, e.u, e.l);
                end else begin
                    o = obs_q[i].pop_front();
                    if ({o.d, o.u, o.l} !== {e.d, e.u, e.l}) begin
                        errors++; $display("FAIL backpressure dut%0d beat: got %h/%b/%b, want %h/%b/%b", i, o.d, o.u, o.l, e.d, e.u, e.l);
                    end
                end
            end
            checks++;
            if (obs_q[i].size() != 0) begin errors++; $display("FAIL backpressure dut%0d extra: got %0d, want 0", i, obs_q[i].size()); obs_q[i].delete(); end
        end
    endtask

    task automatic test_1x1();
        bit ok;
        beat_t o;
        bram[0] = rec(1, 0, 0);
        fg = 8'h5A;
        bg = 8'h11;
        rdy_fix = 1'b1;
        go('1, 1, 1);
        wait_done('1, ok);
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (obs_q[i].size() != 1) begin
                errors++; $display("FAIL 1x1 dut%0d count: got %0d beats, want 1", i, obs_q[i].size());
            end else begin
                o = obs_q[i].pop_front();
                checks++;
                if ({o.d, o.u, o.l} !== {8'h5A, 1'b1, 1'b1}) begin
                    errors++; $display("FAIL 1x1 dut%0d beat: got %h/%b/%b, want 5a/1/1", i, o.d, o.u, o.l);
                end
            end
            obs_q[i].delete();
        end
    endtask

    task automatic test_ignored_start();
        bit ok;
        beat_t e, o;
        int rc [ND];
        load_4x3();
        push_frame('1, 4, 3);
        go('1, 4, 3);
        tick();
        tick();
        go('1, 2, 2);
        wait_done('1, ok);
        for (int i = 0; i < ND; i++) begin
            while (exp_q[i].size() != 0) begin
                e = exp_q[i].pop_front();
                checks++;
                if (obs_q[i].size() == 0) begin
                    errors++; $display("FAIL busy_start dut%0d beat: got none, want %h/%b/%b", i, e.d, e.u, e.l);
                end else begin
                    o = obs_q[i].pop_front();
                    if ({o.d, o.u, o.l} !== {e.d, e.u, e.l}) begin
                        errors++; $display("FAIL busy_start dut%0d beat: got %h/%b/%b, want %h/%b/%b", i, o.d, o.u, o.l, e.d, e.u, e.l);
                    end
                end
            end
            checks++;
            if (obs_q[i].size() != 0) begin errors++; $display("FAIL busy_start dut%0d extra: got %0d, want 0", i, obs_q[i].size()); obs_q[i].delete(); end
            rc[i] = rd_cnt[i];
        end
        go('1, 4, 0);
        for (int n = 0; n < 20; n++) tick();
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (rd_cnt[i] != rc[i] || busy[i] !== 1'b0 || obs_q[i].size() != 0) begin
                errors++;
                $display("FAIL zero_dim dut%0d: reads=%0d busy=%b beats=%0d, want 0/0/0", i, rd_cnt[i] - rc[i], busy[i], obs_q[i].size());
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        beat_t e, o;
        load_4x3();
        rand_mode = 1'b1;
        go('1, 4, 3);
        for (int n = 0; n < 5; n++) tick();
        #2 resetn = 1'b0;
        #1;
        for (int i = 0; i < ND; i++) begin
            checks++;
            if ({busy[i], rd_en[i], rd_addr[i], tv[i], td[i], tu[i], tl[i]} !== '0) begin
                errors++;
                $display("FAIL midreset dut%0d: outputs=%h, want 0", i, {busy[i], rd_en[i], rd_addr[i], tv[i], td[i], tu[i], tl[i]});
            end
        end
        tick();
        for (int i = 0; i < ND; i++) begin obs_q[i].delete(); exp_q[i].delete(); end
        resetn = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (obs_q[i].size() != 0 || busy[i] !== 1'b0) begin
                errors++; $display("FAIL midreset dut%0d stale: beats=%0d busy=%b, want 0/0", i, obs_q[i].size(), busy[i]);
            end
            obs_q[i].delete();
        end
        push_frame('1, 4, 3);
        go('1, 4, 3);
        wait_done('1, ok);
        rand_mode = 1'b0;
        for (int i = 0; i < ND; i++) begin
            while (exp_q[i].size() != 0) begin
                e = exp_q[i].pop_front();
                checks++;
                if (obs_q[i].size() == 0) begin
                    errors++; $display("FAIL midreset dut%0d beat: got none, want %h/%b/%b", i, e.d, e.u, e.l);
                end else begin
                    o = obs_q[i].pop_front();
                    if ({o.d, o.u, o.l} !== {e.d, e.u, e.l}) begin
                        errors++; $display("FAIL midreset dut%0d beat: got %h/%b/%b, want %h/%b/%b", i, o.d, o.u, o.l, e.d, e.u, e.l);
                    end
                end
            end
            checks++;
            if (obs_q[i].size() != 0) begin errors++; $display("FAIL midreset dut%0d extra: got %0d, want 0", i, obs_q[i].size()); obs_q[i].delete(); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok, found;
        beat_t e, o;
        load_4x3();
        rdy_fix = 1'b1;
        push_frame(3'b010, 2, 2);
        go(3'b010, 2, 2);
        found = 1'b0;
        for (int n = 0; n < 500 && !found; n++) begin
            tick();
            if (busy[1] && !tv[1] && obs_q[1].size() == 4) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL b2b drain: found=%0b, want 1", found); end
        width = 3;
        height = 1;
        start_v = 3'b010;
        tick();
        checks++;
        if (busy[1] !== 1'b0) begin errors++; $display("FAIL b2b busy_fall: got %b, want 0", busy[1]); end
        width = 2;
        push_frame(3'b010, 2, 1);
        tick();
        start_v = '0;
        wait_done(3'b010, ok);
        while (exp_q[1].size() != 0) begin
            e = exp_q[1].pop_front();
            checks++;
            if (obs_q[1].size() == 0) begin
                errors++; $display("FAIL b2b beat: got none, want %h/%b/%b", e.d, e.u, e.l);
            end else begin
                o = obs_q[1].pop_front();
                if ({o.d, o.u, o.l} !== {e.d, e.u, e.l}) begin
                    errors++; $display("FAIL b2b beat: got %h/%b/%b, want %h/%b/%b", o.d, o.u, o.l, e.d, e.u, e.l);
                end
            end
        end
        checks++;
        if (obs_q[1].size() != 0) begin errors++; $display("FAIL b2b extra: got %0d, want 0", obs_q[1].size()); obs_q[1].delete(); end
    endtask

    task automatic test_latency();
        bit ok;
        beat_t e, o;
        for (int c = 0; c < 8; c++) bram[c] = rec(c != 5, c % 2, (c + 1) % 3);
        fg = 8'hA5;
        bg = 8'h3C;
        rand_mode = 1'b1;
        push_frame('1, 8, 2);
        go('1, 8, 2);
        wait_done('1, ok);
        rand_mode = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL latency timeout: done=%0b, want 1", ok); end
        for (int i = 0; i < ND; i++) begin
            while (exp_q[i].size() != 0) begin
                e = exp_q[i].pop_front();
                checks++;
                if (obs_q[i].size() == 0) begin
                    errors++; $display("FAIL latency dut%0d beat: got none, want %h/%b/%b", i, e.d, e.u, e.l);
                end else begin
                    o = obs_q[i].pop_front();
                    if ({o.d, o.u, o.l} !== {e.d, e.u, e.l}) begin
                        errors++; $display("FAIL latency dut%0d beat: got %h/%b/%b, want %h/%b/%b", i, o.d, o.u, o.l, e.d, e.u, e.l);
                    end
                end
            end
            checks++;
            if (obs_q[i].size() != 0) begin errors++; $display("FAIL latency dut%0d extra: got %0d, want 0", i, obs_q[i].size()); obs_q[i].delete(); end
        end
    endtask

    initial begin
        for (int i = 0; i < ND; i++) begin stall_err[i] = 0; outst[i] = 0; max_out[i] = 0; rd_cnt[i] = 0; end
        for (int c = 0; c < 16; c++) bram[c] = '0;
        test_reset();
        test_frame_4x3();
        test_backpressure();
        test_1x1();
        test_ignored_start();
        test_reset_midframe();
        test_back_to_back();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fsa_render.md
Name: fsa_render

Overview:
- Reader/transmitter counterpart to the column-scan core. After a frame has been analysed, this block reads the per-column block-RAM records {valid, top, bottom} back out.
- It renders them as an AXI4-Stream video frame: a foreground pixel where the column is valid and top <= y <= bottom, background elsewhere.
- It sits between the column-state BRAM read port and the overlay/VDMA stream path.

Parameters:
- C_PIXEL_WIDTH, 8, output pixel width.
- C_IMG_HW, 12, height / row-index width.
- C_IMG_WW, 12, width / column-index width.
- BR_DW, 32, BRAM data width.
- BR_AW, 12, BRAM address width; equals C_IMG_WW.
- C_RD_LATENCY, 2, cycles from rd_en/rd_addr presented to rd_data valid (1..3).
- C_FIFO_DEPTH, 8, output buffer depth in entries; power of 2, at least C_RD_LATENCY+2.

Ports:
- clk, input, 1, clock.
- resetn, input, 1, asynchronous active-low reset.
- height, input, C_IMG_HW, frame height; sampled at start.
- width, input, C_IMG_WW, frame width; sampled at start.
- fg_data, input, C_PIXEL_WIDTH, foreground pixel value; sampled at start.
- bg_data, input, C_PIXEL_WIDTH, background pixel value; sampled at start.
- start, input, 1, one-cycle frame request.
- busy, output, 1, frame in progress.
- rd_en, output, 1, BRAM read enable.
- rd_addr, output, BR_AW, BRAM column address.
- rd_data, input, BR_DW, BRAM record: bot [C_IMG_HW-1:0], top [2*C_IMG_HW-1:C_IMG_HW], valid bit [2*C_IMG_HW].
- m_axis_tvalid, output, 1, AXI4-Stream valid.
- m_axis_tdata, output, C_PIXEL_WIDTH, pixel.
- m_axis_tuser, output, 1, start of frame.
- m_axis_tlast, output, 1, end of line.
- m_axis_tready, input, 1, AXI4-Stream ready.

Behaviour:
- Reset (async, resetn=0): busy=0, rd_en=0, rd_addr=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0.
  - FIFO, in-flight counter and FSM are cleared immediately.
  - A reset mid-frame aborts the frame; no partial-frame resume.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN: on start=1 with height!=0 and width!=0. Latch height, width, fg_data, bg_data; x=0, y=0; busy=1 on the next cycle.
  - start while busy is ignored. start with a zero dimension is ignored and the FSM stays in IDLE.
  - RUN: each cycle an issue condition is checked; when it holds, assert rd_en=1 with rd_addr=x and advance (x,y) in raster order.
    - Issue condition: fifo_count + inflight + 1 <= C_FIFO_DEPTH.
    - Raster advance: x wraps at width-1 to 0 and y increments.
    - After issuing (width-1, height-1), go to DRAIN.
    - rd_en=0 on cycles without an issue.
  - DRAIN -> IDLE: when inflight=0, FIFO empty, and the last beat has handshaked. busy drops in the same cycle the FSM enters IDLE.
- Read pipeline:
  - A side-band pipe of depth C_RD_LATENCY carries {y, first, eol}:
    - first = (x==0 && y==0).
    - eol = (x==width-1).
  - When rd_data returns, compute the pixel: pix = (valid && top<=y && y<=bot) ? fg : bg. Compare unsigned at C_IMG_HW width.
  - Push {pix, first, eol} into the FIFO.
  - inflight increments on issue and decrements on return; simultaneous issue and return leave it unchanged.
- Output:
  - m_axis_tvalid = FIFO not empty; tdata/tuser/tlast come from the FIFO head.
  - Pop on tvalid && tready.
  - tvalid never drops without a handshake, and head data is stable while tvalid=1 && tready=0.
  - Throughput is 1 pixel/clk when tready is held at 1.
  - The credit check guarantees no FIFO overflow; simultaneous push and pop keep the count constant.
- Boundaries:
  - width=1: tlast on every beat.
  - height=1: a single line, with tuser and tlast both on the first beat when width=1.
  - Maximum dimensions (2^C_IMG_WW-1) wrap the counters without overflow.
  - A record with valid=1 and top>bot yields all background for that column.
  - Back-to-back frames: start in the same cycle that busy falls is ignored; start on the following cycle is accepted.

Test Plan:
- Reset mid-frame → no partial output:
  - Stimulus: assert resetn=0 during RUN, with tready toggling.
  - Required: all outputs go 0 asynchronously; after release, no stale beats; a new start produces a clean frame beginning with tuser=1.
- 4x3 frame, mixed column records, tready=1:
  - Stimulus: width=4, height=3, fg=0xFF, bg=0x00. BRAM col0 = {v=1, top=0, bot=2}, col1 = {v=0}, col2 = {v=1, top=1, bot=1}, col3 = {v=1, top=2, bot=0}.
  - Required: rows FF,00,00,00 / FF,00,FF,00 / FF,00,00,00.
  - Required: tuser only on beat 0, tlast on beats 3, 7, 11, 12 beats at 1/clk, then busy=0.
- Random backpressure (tready 30% duty) on the same frame → identical beat sequence, no drop or duplicate, data stable while stalled, rd_en never issued beyond C_FIFO_DEPTH credits.
- width=1, height=1, col0 = {v=1, top=0, bot=0} → exactly one beat: tdata=fg, tuser=1, tlast=1.
- start pulsed while busy, and start with height=0 → ignored; rd_en remains 0 in the zero-dimension case.
- C_RD_LATENCY=1 and 3 builds, 8x2 frame → pixel order and tlast positions match a reference model.
